// File: rtl/pc_alu_pkg.sv
// rtl/pc_alu_pkg.sv - shared widths, ALU opcode encodings and flag record for pc_alu_unit
package pc_alu_pkg;

  localparam int PC_W   = 12;
  localparam int DATA_W = 8;
  localparam int OP_W   = 5;

  typedef enum logic [OP_W-1:0] {
    OP_DEC  = 5'b00010,
    OP_CMP  = 5'b00101,
    OP_ADD  = 5'b01101,
    OP_SUB  = 5'b01110,
    OP_AND  = 5'b01111,
    OP_XOR  = 5'b10000,
    OP_LSR  = 5'b10001,
    OP_RSC  = 5'b10010,
    OP_LSL  = 5'b10011,
    OP_LSC  = 5'b10100,
    OP_OR   = 5'b10101,
    OP_ADDS = 5'b10110,
    OP_SUBS = 5'b10111
  } alu_op_e;

  typedef struct packed {
    logic equal;
    logic gt;
    logic lt;
    logic zero;
    logic carry;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - purely combinational 8-bit ALU: opcode decode, result, carry-out and compare flags
module alu_core
  import pc_alu_pkg::*;
(
  input  logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              c_i,
  output logic [DATA_W-1:0] rslt,
  output logic              c_o,
  output logic              equal,
  output logic              gt,
  output logic              lt,
  output logic              zero
);

  // One extra bit above the data width carries the add carry or subtract borrow.
  logic [DATA_W:0] ext_a;
  logic [DATA_W:0] ext_b;
  logic [DATA_W:0] ext_ci;
  logic [DATA_W:0] ext_one;
  logic [DATA_W:0] wide;
  logic            is_cmp;

  assign ext_a   = {1'b0, in_a};
  assign ext_b   = {1'b0, in_b};
  assign ext_ci  = {{DATA_W{1'b0}}, c_i};
  assign ext_one = {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    wide = '0;
    rslt = '0;
    c_o  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        wide = ext_a + ext_b;
        rslt = wide[DATA_W-1:0];
        c_o  = wide[DATA_W];
      end
      OP_ADDS: begin
        wide = ext_a + ext_b + ext_ci;
        rslt = wide[DATA_W-1:0];
        c_o  = wide[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        wide = ext_a - ext_b;
        rslt = wide[DATA_W-1:0];
        c_o  = wide[DATA_W];
      end
      OP_SUBS: begin
        wide = ext_a - ext_b - ext_ci;
        rslt = wide[DATA_W-1:0];
        c_o  = wide[DATA_W];
      end
      OP_DEC: begin
        wide = ext_a - ext_one;
        rslt = wide[DATA_W-1:0];
        c_o  = wide[DATA_W];
      end
      OP_AND: rslt = in_a & in_b;
      OP_OR:  rslt = in_a | in_b;
      OP_XOR: rslt = in_a ^ in_b;
      OP_LSR: begin
        rslt = {1'b0, in_a[DATA_W-1:1]};
        c_o  = in_a[0];
      end
      OP_LSL: begin
        rslt = {in_a[DATA_W-2:0], 1'b0};
        c_o  = in_a[DATA_W-1];
      end
      OP_RSC: begin
        rslt = {c_i, in_a[DATA_W-1:1]};
        c_o  = in_a[0];
      end
      OP_LSC: begin
        rslt = {in_a[DATA_W-2:0], c_i};
        c_o  = in_a[DATA_W-1];
      end
      default: begin
        rslt = '0;
        c_o  = 1'b0;
      end
    endcase
  end

  // Magnitude flags report only for CMP so stale compares never leak into other ops.
  assign is_cmp = (alu_op == OP_CMP);
  assign equal  = is_cmp && (in_a == in_b);
  assign gt     = is_cmp && (in_a >  in_b);
  assign lt     = is_cmp && (in_a <  in_b);
  assign zero   = (rslt == '0);

endmodule

// File: rtl/pc_alu_unit.sv
// rtl/pc_alu_unit.sv - execute-stage core: PC register, ALU and registered flag bank
// Optional PC_REL_JUMP_EN adds rel_jump for PC-relative jumps; default build jumps absolute only.
module pc_alu_unit
  import pc_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              jump_en,
  input  logic              stall,
`ifdef PC_REL_JUMP_EN
  input  logic              rel_jump,
`endif
  input  logic [PC_W-1:0]   target,
  output logic [PC_W-1:0]   prog_ctr,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              c_i,
  output logic [DATA_W-1:0] rslt,
  output logic              c_o,
  output logic              equal,
  output logic              gt,
  output logic              lt,
  output logic              zero,
  input  logic              flag_we,
  output logic              equal_q,
  output logic              gt_q,
  output logic              lt_q,
  output logic              zero_q,
  output logic              carry_q
);

  logic [PC_W-1:0] pc_q;
  alu_flags_t      flags_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= '0;
    end else if (stall) begin
      pc_q <= pc_q;
    end else if (jump_en) begin
`ifdef PC_REL_JUMP_EN
      // target is already PC_W wide, so a modulo-2^PC_W add equals adding its sign extension.
      pc_q <= rel_jump ? (pc_q + target) : target;
`else
      pc_q <= target;
`endif
    end else begin
      pc_q <= pc_q + 1'b1;
    end
  end

  assign prog_ctr = pc_q;

  alu_core u_alu_core (
    .alu_op (alu_op),
    .in_a   (in_a),
    .in_b   (in_b),
    .c_i    (c_i),
    .rslt   (rslt),
    .c_o    (c_o),
    .equal  (equal),
    .gt     (gt),
    .lt     (lt),
    .zero   (zero)
  );

  // Flag capture deliberately ignores stall: decode may update flags while fetch is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (flag_we) begin
      flags_q <= '{equal: equal, gt: gt, lt: lt, zero: zero, carry: c_o};
    end
  end

  assign equal_q = flags_q.equal;
  assign gt_q    = flags_q.gt;
  assign lt_q    = flags_q.lt;
  assign zero_q  = flags_q.zero;
  assign carry_q = flags_q.carry;

endmodule

// File: tb/tb_pc_alu_unit.sv
// tb/tb_pc_alu_unit.sv - self-checking bench for pc_alu_unit with an arithmetic reference model
module tb_pc_alu_unit;

  logic        clk;
  logic        reset;
  logic        jump_en;
  logic        stall;
`ifdef PC_REL_JUMP_EN
  logic        rel_jump;
`endif
  logic [11:0] target;
  logic [11:0] prog_ctr;
  logic [4:0]  alu_op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        c_i;
  logic [7:0]  rslt;
  logic        c_o;
  logic        equal;
  logic        gt;
  logic        lt;
  logic        zero;
  logic        flag_we;
  logic        equal_q;
  logic        gt_q;
  logic        lt_q;
  logic        zero_q;
  logic        carry_q;

  int checks;
  int errors;

  pc_alu_unit dut (
    .clk      (clk),
    .reset    (reset),
    .jump_en  (jump_en),
    .stall    (stall),
`ifdef PC_REL_JUMP_EN
    .rel_jump (rel_jump),
`endif
    .target   (target),
    .prog_ctr (prog_ctr),
    .alu_op   (alu_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .c_i      (c_i),
    .rslt     (rslt),
    .c_o      (c_o),
    .equal    (equal),
    .gt       (gt),
    .lt       (lt),
    .zero     (zero),
    .flag_we  (flag_we),
    .equal_q  (equal_q),
    .gt_q     (gt_q),
    .lt_q     (lt_q),
    .zero_q   (zero_q),
    .carry_q  (carry_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] ADD  = 5'b01101;
  localparam logic [4:0] ADDS = 5'b10110;
  localparam logic [4:0] SUB  = 5'b01110;
  localparam logic [4:0] SUBS = 5'b10111;
  localparam logic [4:0] DEC  = 5'b00010;
  localparam logic [4:0] CMP  = 5'b00101;
  localparam logic [4:0] AND_ = 5'b01111;
  localparam logic [4:0] OR_  = 5'b10101;
  localparam logic [4:0] XOR_ = 5'b10000;
  localparam logic [4:0] LSR  = 5'b10001;
  localparam logic [4:0] LSL  = 5'b10011;
  localparam logic [4:0] RSC  = 5'b10010;
  localparam logic [4:0] LSC  = 5'b10100;

  // Returns {equal, gt, lt, zero, carry, rslt[7:0]} from integer arithmetic.
  function automatic logic [12:0] ref_alu(input logic [4:0] op, input int a, input int b, input int ci);
    int r, c, eq, g, l;
    logic [7:0] r8;
    r = 0; c = 0; eq = 0; g = 0; l = 0;
    case (op)
      ADD:  begin r = a + b;      c = (r > 255) ? 1 : 0; end
      ADDS: begin r = a + b + ci; c = (r > 255) ? 1 : 0; end
      SUB:  begin r = a - b;      c = (a < b) ? 1 : 0; end
      SUBS: begin r = a - b - ci; c = (a < b + ci) ? 1 : 0; end
      DEC:  begin r = a - 1;      c = (a == 0) ? 1 : 0; end
      CMP:  begin
        r = a - b; c = (a < b) ? 1 : 0;
        eq = (a == b) ? 1 : 0; g = (a > b) ? 1 : 0; l = (a < b) ? 1 : 0;
      end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      LSR:  begin r = a / 2;            c = a % 2; end
      LSL:  begin r = a * 2;            c = a / 128; end
      RSC:  begin r = a / 2 + ci * 128; c = a % 2; end
      LSC:  begin r = a * 2 + ci;       c = a / 128; end
      default: ;
    endcase
    r  = ((r % 256) + 256) % 256;
    r8 = r[7:0];
    return {eq[0], g[0], l[0], (r == 0), c[0], r8};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    flag_we = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (prog_ctr !== 12'h000) begin
      errors++; $display("FAIL reset_pc actual=%h required=000", prog_ctr);
    end
    checks++;
    if ({equal_q, gt_q, lt_q, zero_q, carry_q} !== 5'b00000) begin
      errors++; $display("FAIL reset_flags actual=%b required=00000", {equal_q, gt_q, lt_q, zero_q, carry_q});
    end
    @(negedge clk);
    reset = 1'b1;
    flag_we = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (prog_ctr !== 12'(i)) begin
        errors++; $display("FAIL pc_increment actual=%h required=%h", prog_ctr, 12'(i));
      end
    end
  endtask

  task automatic test_pc_jump_edges();
    @(negedge clk);
    jump_en = 1'b1; target = 12'h257;
    @(posedge clk); #1;
    checks++;
    if (prog_ctr !== 12'h257) begin
      errors++; $display("FAIL pc_jump actual=%h required=257", prog_ctr);
    end
    @(negedge clk);
    target = 12'hFFF;
    @(posedge clk); #1;
    @(negedge clk);
    jump_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (prog_ctr !== 12'h000) begin
      errors++; $display("FAIL pc_wrap actual=%h required=000", prog_ctr);
    end
    @(negedge clk);
    stall = 1'b1; jump_en = 1'b1; target = 12'h5A5;
    @(posedge clk); #1;
    checks++;
    if (prog_ctr !== 12'h000) begin
      errors++; $display("FAIL pc_stall_jump actual=%h required=000", prog_ctr);
    end
    @(negedge clk);
    stall = 1'b0; jump_en = 1'b0;
  endtask

  task automatic test_pc_random();
    int m_pc;
    @(negedge clk);
    jump_en = 1'b1; target = 12'h100;
    @(posedge clk); #1;
    m_pc = 'h100;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      stall   = ($urandom_range(0, 3) == 0);
      jump_en = ($urandom_range(0, 4) == 0);
      target  = 12'($urandom);
      @(posedge clk); #1;
      if (stall) m_pc = m_pc;
      else if (jump_en) m_pc = int'(target);
      else m_pc = (m_pc + 1) % 4096;
      checks++;
      if (prog_ctr !== 12'(m_pc)) begin
        errors++; $display("FAIL pc_random cycle=%0d actual=%h required=%h", i, prog_ctr, 12'(m_pc));
      end
    end
    @(negedge clk);
    stall = 1'b0; jump_en = 1'b0;
  endtask

  typedef struct {
    logic [4:0] op;
    int a, b, ci, r, c, eq, g, l;
  } vec_t;

  task automatic test_alu_directed();
    vec_t tbl[16];
    tbl[0]  = '{ADD,  'h01, 'h04, 0, 'h05, 0, 0, 0, 0};
    tbl[1]  = '{SUB,  'h71, 'h24, 0, 'h4D, 0, 0, 0, 0};
    tbl[2]  = '{ADDS, 'h80, 'h01, 1, 'h82, 0, 0, 0, 0};
    tbl[3]  = '{SUBS, 'h00, 'h01, 0, 'hFF, 1, 0, 0, 0};
    tbl[4]  = '{DEC,  'h02, 'h00, 0, 'h01, 0, 0, 0, 0};
    tbl[5]  = '{DEC,  'h00, 'h00, 0, 'hFF, 1, 0, 0, 0};
    tbl[6]  = '{XOR_, 'h71, 'h24, 0, 'h55, 0, 0, 0, 0};
    tbl[7]  = '{AND_, 'hFF, 'h24, 0, 'h24, 0, 0, 0, 0};
    tbl[8]  = '{OR_,  'hFF, 'h24, 0, 'hFF, 0, 0, 0, 0};
    tbl[9]  = '{LSR,  'h71, 'h00, 0, 'h38, 1, 0, 0, 0};
    tbl[10] = '{LSL,  'h71, 'h00, 0, 'hE2, 0, 0, 0, 0};
    tbl[11] = '{RSC,  'h71, 'h00, 1, 'hB8, 1, 0, 0, 0};
    tbl[12] = '{LSC,  'h71, 'h00, 1, 'hE3, 0, 0, 0, 0};
    tbl[13] = '{CMP,  'h71, 'h71, 0, 'h00, 0, 1, 0, 0};
    tbl[14] = '{CMP,  'h71, 'h70, 0, 'h01, 0, 0, 1, 0};
    tbl[15] = '{CMP,  'h71, 'h72, 0, 'hFF, 1, 0, 0, 1};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      alu_op = tbl[i].op; in_a = 8'(tbl[i].a); in_b = 8'(tbl[i].b); c_i = tbl[i].ci[0];
      #1;
      checks++;
      if ({rslt, c_o} !== {8'(tbl[i].r), tbl[i].c[0]}) begin
        errors++; $display("FAIL alu_directed idx=%0d op=%b actual rslt=%h c_o=%b required rslt=%h c_o=%b",
                           i, tbl[i].op, rslt, c_o, 8'(tbl[i].r), tbl[i].c[0]);
      end
      checks++;
      if ({equal, gt, lt, zero} !== {tbl[i].eq[0], tbl[i].g[0], tbl[i].l[0], (tbl[i].r == 0)}) begin
        errors++; $display("FAIL alu_directed_flags idx=%0d actual=%b required=%b", i, {equal, gt, lt, zero},
                           {tbl[i].eq[0], tbl[i].g[0], tbl[i].l[0], (tbl[i].r == 0)});
      end
    end
  endtask

  task automatic test_alu_random();
    logic [12:0] exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      alu_op = 5'($urandom);
      in_a   = 8'($urandom);
      in_b   = ($urandom_range(0, 7) == 0) ? in_a : 8'($urandom);
      c_i    = 1'($urandom);
      #1;
      exp = ref_alu(alu_op, int'(in_a), int'(in_b), int'(c_i));
      checks++;
      if ({equal, gt, lt, zero, c_o, rslt} !== exp) begin
        errors++; $display("FAIL alu_random op=%b a=%h b=%h ci=%b actual=%h required=%h",
                           alu_op, in_a, in_b, c_i, {equal, gt, lt, zero, c_o, rslt}, exp);
      end
    end
  endtask

  task automatic test_flag_bank();
    logic [4:0]  m_flags;
    logic [12:0] exp;
    @(negedge clk);
    alu_op = CMP; in_a = 8'h71; in_b = 8'h72; c_i = 1'b0; flag_we = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({equal_q, gt_q, lt_q, zero_q, carry_q} !== 5'b00101) begin
      errors++; $display("FAIL flag_capture actual=%b required=00101", {equal_q, gt_q, lt_q, zero_q, carry_q});
    end
    @(negedge clk);
    alu_op = ADD; in_a = 8'h00; in_b = 8'h00; flag_we = 1'b0; stall = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({equal_q, gt_q, lt_q, zero_q, carry_q} !== 5'b00101) begin
      errors++; $display("FAIL flag_hold actual=%b required=00101", {equal_q, gt_q, lt_q, zero_q, carry_q});
    end
    m_flags = 5'b00101;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      alu_op  = ($urandom_range(0, 2) == 0) ? CMP : 5'($urandom);
      in_a    = 8'($urandom);
      in_b    = ($urandom_range(0, 5) == 0) ? in_a : 8'($urandom);
      c_i     = 1'($urandom);
      flag_we = 1'($urandom);
      stall   = 1'($urandom);
      exp = ref_alu(alu_op, int'(in_a), int'(in_b), int'(c_i));
      @(posedge clk); #1;
      if (flag_we) m_flags = exp[12:8];
      checks++;
      if ({equal_q, gt_q, lt_q, zero_q, carry_q} !== m_flags) begin
        errors++; $display("FAIL flag_random cycle=%0d actual=%b required=%b", i,
                           {equal_q, gt_q, lt_q, zero_q, carry_q}, m_flags);
      end
    end
    @(negedge clk);
    stall = 1'b0; flag_we = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({equal_q, gt_q, lt_q, zero_q, carry_q, prog_ctr} !== 17'h0) begin
      errors++; $display("FAIL flag_reset actual flags=%b pc=%h required flags=00000 pc=000",
                         {equal_q, gt_q, lt_q, zero_q, carry_q}, prog_ctr);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    jump_en = 1'b0;
    stall   = 1'b0;
`ifdef PC_REL_JUMP_EN
    rel_jump = 1'b0;
`endif
    target  = '0;
    alu_op  = '0;
    in_a    = '0;
    in_b    = '0;
    c_i     = 1'b0;
    flag_we = 1'b0;
    test_reset();
    test_pc_jump_edges();
    test_pc_random();
    test_alu_directed();
    test_alu_random();
    test_flag_bank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
